// File: rtl/mdu_pkg.sv
// Shared multiply/divide definitions: md_op encodings and default latencies.
// Used by the decoder, the stall unit and the EX-stage multiply/divide unit.
package mdu_pkg;

    localparam int MD_OP_W = 4;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Result of a finished operation; write is low for divide by zero.
    typedef struct packed {
        logic        write;
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    function automatic logic is_muldiv(input logic [MD_OP_W-1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: owns HI/LO, models MULT/DIV latency with a
// down-counter and reports a hazard to the stall unit while work is pending.
module ex_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MD_OP_W-1:0]  md_op,
    input  logic [31:0]         src_a,
    input  logic [31:0]         src_b,
    output logic                busy,
    output logic                md_hazard,
    output logic [31:0]         hi,
    output logic [31:0]         lo,
    output logic [31:0]         md_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [31:0]        hi_reg,    hi_next;
    logic [31:0]        lo_reg,    lo_next;
    logic               busy_reg,  busy_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [MD_OP_W-1:0] op_reg,    op_next;
    logic [31:0]        a_reg,     a_next;
    logic [31:0]        b_reg,     b_next;

    logic               launch;
    logic               finish;
    md_result_t         result;

    // Datapath on the latched operands
    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic        [31:0] safe_b;
    logic signed [32:0] s_dividend;
    logic signed [32:0] s_divisor;
    logic signed [32:0] s_quot;
    logic signed [32:0] s_rem;
    logic        [31:0] u_quot;
    logic        [31:0] u_rem;

    // A zero divisor never commits, so substituting 1 only keeps the divider
    // free of undefined values.
    assign safe_b = (b_reg == 32'd0) ? 32'd1 : b_reg;

    assign sprod = $signed({{32{a_reg[31]}}, a_reg}) * $signed({{32{b_reg[31]}}, b_reg});
    assign uprod = {32'd0, a_reg} * {32'd0, b_reg};

    // 33-bit signed divide keeps 0x80000000 / -1 representable; the low 32
    // bits give the wrapped quotient 0x80000000 with remainder 0.
    assign s_dividend = {a_reg[31], a_reg};
    assign s_divisor  = {safe_b[31], safe_b};
    assign s_quot     = s_dividend / s_divisor;
    assign s_rem      = s_dividend % s_divisor;

    assign u_quot = a_reg / safe_b;
    assign u_rem  = a_reg % safe_b;

    always_comb begin
        result.write = 1'b0;
        result.hi    = hi_reg;
        result.lo    = lo_reg;
        case (op_reg)
            MD_MULT: begin
                result.write = 1'b1;
                result.hi    = sprod[63:32];
                result.lo    = sprod[31:0];
            end
            MD_MULTU: begin
                result.write = 1'b1;
                result.hi    = uprod[63:32];
                result.lo    = uprod[31:0];
            end
            MD_DIV: begin
                result.write = (b_reg != 32'd0);
                result.hi    = s_rem[31:0];
                result.lo    = s_quot[31:0];
            end
            MD_DIVU: begin
                result.write = (b_reg != 32'd0);
                result.hi    = u_rem;
                result.lo    = u_quot;
            end
            default: begin
                result.write = 1'b0;
            end
        endcase
    end

    assign launch = start && !busy_reg && is_muldiv(md_op);
    assign finish = busy_reg && (count_reg == CNT_ONE);

    always_comb begin
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        busy_next  = busy_reg;
        count_next = count_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;

        if (busy_reg) begin
            // start and MTHI/MTLO are deliberately ignored here
            if (finish) begin
                busy_next  = 1'b0;
                count_next = '0;
                if (result.write) begin
                    hi_next = result.hi;
                    lo_next = result.lo;
                end
            end else begin
                count_next = count_reg - CNT_ONE;
            end
        end else if (launch) begin
            op_next    = md_op;
            a_next     = src_a;
            b_next     = src_b;
            busy_next  = 1'b1;
            count_next = is_div(md_op) ? DIV_LOAD : MULT_LOAD;
        end else if (!start) begin
            if (md_op == MD_MTHI) begin
                hi_next = src_a;
            end else if (md_op == MD_MTLO) begin
                lo_next = src_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg    <= '0;
            lo_reg    <= '0;
            busy_reg  <= 1'b0;
            count_reg <= '0;
            op_reg    <= MD_NONE;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            busy_reg  <= busy_next;
            count_reg <= count_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
        end
    end

    assign busy      = busy_reg;
    assign md_hazard = start | busy_reg;
    assign hi        = hi_reg;
    assign lo        = lo_reg;

    always_comb begin
        md_out = 32'd0;
        if (md_op == MD_MFHI) begin
            md_out = hi_reg;
        end else if (md_op == MD_MFLO) begin
            md_out = lo_reg;
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Randomized and directed bench for ex_mdu against an arithmetic model of
// HI/LO and the fixed busy latencies.
module tb_ex_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        md_hazard;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    ex_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .busy      (busy),
        .md_hazard (md_hazard),
        .hi        (hi),
        .lo        (lo),
        .md_out    (md_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Architectural result {hi,lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        longint          sa, sb, q, r, p;
        longint unsigned ua, ub, up;
        logic [63:0]     res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        res = {h, l};
        case (op)
            MD_MULT: begin
                p   = sa * sb;
                res = p;
            end
            MD_MULTU: begin
                up  = ua * ub;
                res = up;
            end
            MD_DIV: if (b != 32'd0) begin
                q   = sa / sb;
                r   = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            MD_DIVU: if (b != 32'd0) begin
                up  = ua / ub;
                ua  = ua % ub;
                res = {ua[31:0], up[31:0]};
            end
            default: res = {h, l};
        endcase
        return res;
    endfunction

    // disrupt: 0 none, 1 start pulse mid-operation, 2 MTLO mid-operation
    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int disrupt, input string tag);
        logic [63:0] res;
        int          n;
        int          want;
        res  = model(op, a, b, exp_hi, exp_lo);
        want = (op == MD_MULT || op == MD_MULTU) ? 5 : 10;
        @(negedge clk);
        start = 1'b1; md_op = op; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            check({tag, " hazard"}, {31'd0, md_hazard}, 32'd1);
            check({tag, " hi held"}, hi, exp_hi);
            check({tag, " md_out idle"}, md_out, 32'd0);
            if (n == 2 && disrupt == 1) begin
                start = 1'b1; md_op = MD_MULT; src_a = $urandom; src_b = $urandom;
            end
            if (n == 2 && disrupt == 2) begin
                md_op = MD_MTLO; src_a = $urandom;
            end
            @(negedge clk);
            start = 1'b0; md_op = MD_NONE;
            if (n == 2 && disrupt != 0) check({tag, " lo held"}, lo, exp_lo);
        end
        check({tag, " busy cycles"}, 32'(n), 32'(want));
        exp_hi = res[63:32];
        exp_lo = res[31:0];
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        $display("[TB] %s op=%0d a=%08h b=%08h -> hi=%08h lo=%08h busy=%0d", tag, op, a, b, hi, lo, n);
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] val, input string tag);
        @(negedge clk);
        start = 1'b0; md_op = op; src_a = val;
        @(negedge clk);
        md_op = MD_NONE;
        if (op == MD_MTHI) exp_hi = val; else exp_lo = val;
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        md_op = MD_MFHI; #1;
        check({tag, " mfhi"}, md_out, exp_hi);
        md_op = MD_MFLO; #1;
        check({tag, " mflo"}, md_out, exp_lo);
        md_op = MD_NONE; #1;
        check({tag, " md_out none"}, md_out, 32'd0);
        $display("[TB] %s op=%0d val=%08h -> hi=%08h lo=%08h", tag, op, val, hi, lo);
    endtask

    initial begin
        int          n;
        logic [3:0]  op;
        logic [31:0] a, b;

        reset = 1'b1; start = 1'b0; md_op = MD_NONE; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset hazard", {31'd0, md_hazard}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        reset = 1'b0;

        run_md(MD_MULT, 32'hFFFFFFFE, 32'd3, 0, "mult -2*3");
        check("mult -2*3 hi const", hi, 32'hFFFFFFFF);
        check("mult -2*3 lo const", lo, 32'hFFFFFFFA);
        run_md(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "multu max");
        check("multu hi const", hi, 32'hFFFFFFFE);
        check("multu lo const", lo, 32'h00000001);
        run_md(MD_DIV, 32'hFFFFFFF9, 32'd2, 0, "div -7/2");
        check("div -7/2 lo const", lo, 32'hFFFFFFFD);
        check("div -7/2 hi const", hi, 32'hFFFFFFFF);
        run_md(MD_DIVU, 32'd7, 32'd2, 0, "divu 7/2");
        run_md(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0, "div ovf");
        check("div ovf lo const", lo, 32'h80000000);
        check("div ovf hi const", hi, 32'd0);

        mt(MD_MTHI, 32'h12345678, "mthi pre");
        mt(MD_MTLO, 32'h12345678, "mtlo pre");
        run_md(MD_DIV, 32'd99, 32'd0, 0, "div by 0");
        run_md(MD_DIVU, 32'hDEADBEEF, 32'd0, 0, "divu by 0");
        mt(MD_MTHI, 32'hA5A5A5A5, "mthi a5");

        run_md(MD_DIVU, 32'd1000, 32'd7, 2, "mtlo busy");
        run_md(MD_DIV, 32'hFFFFFF9C, 32'd7, 1, "start busy");

        // start with a non-mult/div op neither launches nor moves HI
        @(negedge clk);
        start = 1'b1; md_op = MD_MTHI; src_a = 32'h0BADF00D;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        check("start mthi busy", {31'd0, busy}, 32'd0);
        check("start mthi hi", hi, exp_hi);
        $display("[TB] start+mthi ignored hi=%08h busy=%0d", hi, busy);

        for (int i = 0; i < 50; i++) begin
            op = 4'($urandom_range(1, 6));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 4) == 0) b = 32'd0;
            if (op == 4'd5)      mt(MD_MTHI, a, "rand mthi");
            else if (op == 4'd6) mt(MD_MTLO, a, "rand mtlo");
            else                 run_md(op, a, b, 0, "rand md");
        end

        // reset in the third busy cycle of a divide discards the result
        @(negedge clk);
        start = 1'b1; md_op = MD_DIV; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        n = 1;
        while (busy === 1'b1 && n < 3) begin
            n++;
            @(negedge clk);
        end
        check("rst busy before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        check("rst abort busy", {31'd0, busy}, 32'd0);
        check("rst abort hi", hi, exp_hi);
        check("rst abort lo", lo, exp_lo);
        repeat (15) @(negedge clk);
        check("rst later busy", {31'd0, busy}, 32'd0);
        check("rst later hi", hi, exp_hi);
        check("rst later lo", lo, exp_lo);
        $display("[TB] reset mid-div hi=%08h lo=%08h busy=%0d", hi, lo, busy);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
